vga_sync_probe: RTL
===================

Name: vga_sync_probe

Overview:
- TinyQV peripheral that receives a VGA stream on the input PMOD, using the TinyVGA pin order: ui_in = {hsync, B0, G0, R0, vsync, B1, G1, R1}.
- It measures line and frame timing, tracks sync lock, and captures the RGB value at one programmable pixel coordinate.
- It is the receive end of the video interface our console peripherals drive, used for loopback self-test and for external-source detection.
- Registers sit on the standard peripheral bus; the interrupt fires at frame start.

Parameters:
- CNT_W, 11, width of the x/y counters and of all measured timing registers; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ui_in  in  8  VGA input; already synchronised by the top level.
- uo_out  out  8  tied to 0.
- address  in  6  register address.
- data_in  in  32  write data; only the low bits are used.
- data_write_n  in  2  11 = no write; any other value is a write.
- data_read_n  in  2  11 = no read.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  constant 1.
- user_interrupt  out  1  frame-start interrupt.

Behaviour:
- Input stage: ui_in is registered once into s; prev holds the previous s. hs = s[7]^~hpol, vs = s[3]^~vpol (pol bit 0 = sync active-low). Events derived from s vs prev:
  - h_asr / h_dea: hsync becomes active / inactive.
  - v_asr / v_dea: vsync becomes active / inactive.
  - rgb = {s[6]B0|s[2]B1, ...} packed as {B1,B0,G1,G0,R1,R0}.
- Registers, byte offsets; unused bits read 0; all reset to 0:
  - 0x00 CTRL RW: [0] en, [1] hpol, [2] vpol, [3] irq_en.
  - 0x04 SAMPLE_X RW.
  - 0x08 SAMPLE_Y RW.
  - 0x0C HTOTAL RO.
  - 0x10 HSYNC_W RO.
  - 0x14 VTOTAL RO.
  - 0x18 VSYNC_W RO.
  - 0x1C SAMPLE RO: [5:0] rgb.
  - 0x3C STATUS RO: [0] irq, [1] locked, [2] sample_valid, [4:3] lock state.
  - Other addresses read 0.
- x_cnt:
  - On h_asr: HTOTAL <= x_cnt+1, x_cnt <= 0.
  - On h_dea: HSYNC_W <= x_cnt+1.
  - Otherwise increments, saturating at max.
- y_cnt:
  - On v_asr: VTOTAL <= y_cnt+1, y_cnt <= 0; v_asr wins over a coincident h_asr.
  - On h_asr alone: y_cnt+1, saturating.
  - On v_dea: VSYNC_W <= y_cnt+1.
- Measured registers update on every event, including while unlocked. All +1 results saturate.
- line_err: set when h_asr yields a new HTOTAL differing from the current HTOTAL; cleared on v_asr.
- Lock FSM, evaluated on v_asr using the pre-update values:
  - frame_ok = HTOTAL nonzero and unsaturated, and y_cnt unsaturated.
  - UNLOCKED -> CHECK if frame_ok.
  - CHECK -> LOCKED if frame_ok, !line_err and y_cnt+1 == VTOTAL; else CHECK if frame_ok, else UNLOCKED.
  - LOCKED -> UNLOCKED if !frame_ok, line_err or a VTOTAL mismatch.
  - Any state -> UNLOCKED when x_cnt reaches saturation (no hsync timeout).
- Sampling: on a cycle with x_cnt == SAMPLE_X, y_cnt == SAMPLE_Y and no h/v event, SAMPLE <= rgb and sample_valid <= 1. Later matches overwrite.
  - sample_valid clears on a read of 0x1C or a write to 0x04/0x08.
  - Sampling wins over a simultaneous clear.
- irq: set on v_asr when irq_en and the state before the event is LOCKED; cleared by a read of 0x3C. Set wins over clear.
- en = 0: x_cnt, y_cnt, line_err and FSM held at 0/UNLOCKED; no events, no samples; measured registers hold their values.
- rst mid-frame: all state returns to reset values on the next edge; measurement restarts from the next events.

Test Plan:
- Reset, then read all registers -> all 0, user_interrupt 0, data_ready 1.
- en=1, pol active-low, synthetic timing (40 clk/line, hsync 4 clk, 10 lines/frame, vsync 2 lines aligned to hsync) -> HTOTAL 40, HSYNC_W 4, VTOTAL 10, VSYNC_W 2; locked=1 no later than the 3rd v_asr.
- Same stream with hpol=vpol=1 and inverted syncs -> identical measurements and lock.
- SAMPLE_X=12, SAMPLE_Y=3, input RGB=6'b101101 only during that pixel -> SAMPLE=0x2D, sample_valid=1; read 0x1C -> sample_valid 0.
- irq_en=1 while locked -> user_interrupt rises one cycle after the v_asr edge; STATUS read clears it; read coincident with a new v_asr leaves it 1.
- Locked, then change one line to 41 clocks -> UNLOCKED at the next v_asr; then stop hsync for 2047 clocks -> x_cnt saturates, locked 0; restore the stream -> relock within 3 frames.

Source files
------------

// File: rtl/vga_sync_probe.sv
// vga_sync_probe: TinyQV peripheral that receives a TinyVGA-ordered stream, measures line and
// frame timing, tracks sync lock and captures the colour of one programmable pixel.
module vga_sync_probe #(
    parameter int CNT_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_SAMPLE_X = 6'h04;
    localparam logic [5:0] ADDR_SAMPLE_Y = 6'h08;
    localparam logic [5:0] ADDR_HTOTAL   = 6'h0C;
    localparam logic [5:0] ADDR_HSYNC_W  = 6'h10;
    localparam logic [5:0] ADDR_VTOTAL   = 6'h14;
    localparam logic [5:0] ADDR_VSYNC_W  = 6'h18;
    localparam logic [5:0] ADDR_SAMPLE   = 6'h1C;
    localparam logic [5:0] ADDR_STATUS   = 6'h3C;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
        zext = {{(32-CNT_W){1'b0}}, v};
    endfunction

    logic [7:0]       in_r;
    logic [7:0]       prev_r;
    logic [3:0]       ctrl_r;
    logic [CNT_W-1:0] sample_x_r;
    logic [CNT_W-1:0] sample_y_r;
    logic [CNT_W-1:0] htotal_r;
    logic [CNT_W-1:0] hsync_w_r;
    logic [CNT_W-1:0] vtotal_r;
    logic [CNT_W-1:0] vsync_w_r;
    logic [CNT_W-1:0] x_cnt_r;
    logic [CNT_W-1:0] y_cnt_r;
    logic             line_err_r;
    logic [5:0]       sample_r;
    logic             sample_valid_r;
    logic             irq_r;
    lock_state_t      state_r;
    lock_state_t      state_nx_s;

    logic en_s, hpol_s, vpol_s, irq_en_s;
    logic hs_now_s, hs_prev_s, vs_now_s, vs_prev_s;
    logic h_asr_s, h_dea_s, v_asr_s, v_dea_s, any_event_s;
    logic wr_s, rd_s, clear_valid_s, sample_hit_s;
    logic frame_ok_s, vt_match_s;
    logic [CNT_W-1:0] x_inc_s, y_inc_s;
    logic [5:0] rgb_s;
    logic unused_s;

    assign en_s     = ctrl_r[0];
    assign hpol_s   = ctrl_r[1];
    assign vpol_s   = ctrl_r[2];
    assign irq_en_s = ctrl_r[3];

    // Polarity bit 0 means the pin idles high and pulses low.
    assign hs_now_s  = in_r[7]   ^ ~hpol_s;
    assign hs_prev_s = prev_r[7] ^ ~hpol_s;
    assign vs_now_s  = in_r[3]   ^ ~vpol_s;
    assign vs_prev_s = prev_r[3] ^ ~vpol_s;

    assign h_asr_s     = en_s &  hs_now_s & ~hs_prev_s;
    assign h_dea_s     = en_s & ~hs_now_s &  hs_prev_s;
    assign v_asr_s     = en_s &  vs_now_s & ~vs_prev_s;
    assign v_dea_s     = en_s & ~vs_now_s &  vs_prev_s;
    assign any_event_s = h_asr_s | h_dea_s | v_asr_s | v_dea_s;

    assign rgb_s = {in_r[2], in_r[6], in_r[1], in_r[5], in_r[0], in_r[4]};

    assign x_inc_s    = sat_inc(x_cnt_r);
    assign y_inc_s    = sat_inc(y_cnt_r);
    assign frame_ok_s = (htotal_r != CNT_ZERO) && (htotal_r != CNT_MAX) && (y_cnt_r != CNT_MAX);
    assign vt_match_s = (y_inc_s == vtotal_r);

    assign wr_s          = (data_write_n != 2'b11);
    assign rd_s          = (data_read_n != 2'b11);
    assign clear_valid_s = (rd_s && address == ADDR_SAMPLE) ||
                           (wr_s && (address == ADDR_SAMPLE_X || address == ADDR_SAMPLE_Y));
    assign sample_hit_s  = en_s && !any_event_s && (x_cnt_r == sample_x_r) && (y_cnt_r == sample_y_r);

    assign uo_out         = 8'h00;
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_r;
    assign unused_s       = &{1'b0, data_in[31:CNT_W]};

    // Input capture and edge-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_r   <= 8'h00;
            prev_r <= 8'h00;
        end else begin
            in_r   <= ui_in;
            prev_r <= in_r;
        end
    end

    // Bus-writable configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r     <= 4'h0;
            sample_x_r <= CNT_ZERO;
            sample_y_r <= CNT_ZERO;
        end else begin
            if (wr_s && address == ADDR_CTRL) begin
                ctrl_r <= data_in[3:0];
            end
            if (wr_s && address == ADDR_SAMPLE_X) begin
                sample_x_r <= data_in[CNT_W-1:0];
            end
            if (wr_s && address == ADDR_SAMPLE_Y) begin
                sample_y_r <= data_in[CNT_W-1:0];
            end
        end
    end

    // Position counters, timing measurements and per-frame line consistency.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_r    <= CNT_ZERO;
            y_cnt_r    <= CNT_ZERO;
            htotal_r   <= CNT_ZERO;
            hsync_w_r  <= CNT_ZERO;
            vtotal_r   <= CNT_ZERO;
            vsync_w_r  <= CNT_ZERO;
            line_err_r <= 1'b0;
        end else if (!en_s) begin
            x_cnt_r    <= CNT_ZERO;
            y_cnt_r    <= CNT_ZERO;
            line_err_r <= 1'b0;
        end else begin
            if (h_asr_s) begin
                htotal_r <= x_inc_s;
                x_cnt_r  <= CNT_ZERO;
            end else begin
                x_cnt_r  <= x_inc_s;
            end
            if (h_dea_s) begin
                hsync_w_r <= x_inc_s;
            end
            // A frame start resets the line count even when a line start coincides.
            if (v_asr_s) begin
                vtotal_r <= y_inc_s;
                y_cnt_r  <= CNT_ZERO;
            end else if (h_asr_s) begin
                y_cnt_r  <= y_inc_s;
            end
            if (v_dea_s) begin
                vsync_w_r <= y_inc_s;
            end
            if (v_asr_s) begin
                line_err_r <= 1'b0;
            end else if (h_asr_s && (x_inc_s != htotal_r)) begin
                line_err_r <= 1'b1;
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_UNLOCKED;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Lock next-state: judged at each frame start on the frame just finished.
    always_comb begin
        state_nx_s = state_r;
        if (!en_s) begin
            state_nx_s = ST_UNLOCKED;
        end else if (x_cnt_r == CNT_MAX) begin
            state_nx_s = ST_UNLOCKED;
        end else if (v_asr_s) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (frame_ok_s) state_nx_s = ST_CHECK;
                    else            state_nx_s = ST_UNLOCKED;
                end
                ST_CHECK: begin
                    if (frame_ok_s && !line_err_r && vt_match_s) state_nx_s = ST_LOCKED;
                    else if (frame_ok_s)                         state_nx_s = ST_CHECK;
                    else                                         state_nx_s = ST_UNLOCKED;
                end
                ST_LOCKED: begin
                    if (frame_ok_s && !line_err_r && vt_match_s) state_nx_s = ST_LOCKED;
                    else                                         state_nx_s = ST_UNLOCKED;
                end
                default: state_nx_s = ST_UNLOCKED;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Pixel capture and frame-start interrupt; a new capture or set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r       <= 6'd0;
            sample_valid_r <= 1'b0;
            irq_r          <= 1'b0;
        end else begin
            if (sample_hit_s) begin
                sample_r       <= rgb_s;
                sample_valid_r <= 1'b1;
            end else if (clear_valid_s) begin
                sample_valid_r <= 1'b0;
            end
            if (v_asr_s && irq_en_s && state_r == ST_LOCKED) begin
                irq_r <= 1'b1;
            end else if (rd_s && address == ADDR_STATUS) begin
                irq_r <= 1'b0;
            end
        end
    end

    // Register read mux.
    always_comb begin
        data_out = 32'h0000_0000;
        case (address)
            ADDR_CTRL:     data_out = {28'h000_0000, ctrl_r};
            ADDR_SAMPLE_X: data_out = zext(sample_x_r);
            ADDR_SAMPLE_Y: data_out = zext(sample_y_r);
            ADDR_HTOTAL:   data_out = zext(htotal_r);
            ADDR_HSYNC_W:  data_out = zext(hsync_w_r);
            ADDR_VTOTAL:   data_out = zext(vtotal_r);
            ADDR_VSYNC_W:  data_out = zext(vsync_w_r);
            ADDR_SAMPLE:   data_out = {26'h000_0000, sample_r};
            ADDR_STATUS:   data_out = {27'h000_0000, state_r, sample_valid_r,
                                       (state_r == ST_LOCKED), irq_r};
            default:       data_out = 32'h0000_0000;
        endcase
    end
endmodule
